// File: rtl/gemm_job_scheduler.sv
// GeMM job scheduler: buffers host jobs in a small FIFO and runs them on the
// accelerator one at a time. For each job it holds the sizes stable, pulses
// start, and waits for done. It then returns a completion record with the tag,
// the run-cycle count and a zero-size error flag.
module gemm_job_scheduler #(
  parameter int SizeAddrWidth = 8,
  parameter int IdWidth       = 4,
  parameter int QueueDepth    = 4,
  parameter int CycleWidth    = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             job_valid_i,
  output logic                             job_ready_o,
  input  logic [SizeAddrWidth-1:0]         job_m_i,
  input  logic [SizeAddrWidth-1:0]         job_k_i,
  input  logic [SizeAddrWidth-1:0]         job_n_i,
  input  logic [IdWidth-1:0]               job_id_i,
  output logic                             gemm_start_o,
  output logic [SizeAddrWidth-1:0]         gemm_m_size_o,
  output logic [SizeAddrWidth-1:0]         gemm_k_size_o,
  output logic [SizeAddrWidth-1:0]         gemm_n_size_o,
  input  logic                             gemm_done_i,
  output logic                             cpl_valid_o,
  input  logic                             cpl_ready_i,
  output logic [IdWidth-1:0]               cpl_id_o,
  output logic [CycleWidth-1:0]            cpl_cycles_o,
  output logic                             cpl_err_o,
  output logic                             busy_o,
  output logic [$clog2(QueueDepth+1)-1:0]  queue_level_o
);

  localparam int PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int LvlW = $clog2(QueueDepth + 1);

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [SizeAddrWidth-1:0] m;
    logic [SizeAddrWidth-1:0] k;
    logic [SizeAddrWidth-1:0] n;
  } job_t;

  typedef enum logic [1:0] {IDLE, START, RUN, CPL} state_t;

  state_t          state, state_next;
  job_t            mem [QueueDepth];
  job_t            head;
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [LvlW-1:0] level, level_next;
  logic            ready_q;
  logic            push, pop;
  logic            head_zero;

  logic [CycleWidth-1:0] run_cnt, run_inc;
  logic [IdWidth-1:0]    tag_q;
  logic [CycleWidth-1:0] cycles_q;
  logic                  err_q;

  // ---------------------------------------------------------------- FIFO
  // Ready is registered from the next occupancy, so it reads as !full
  // during normal operation. It is also 0 while reset is held. A pop in
  // the same cycle as a full FIFO does not open the slot early.
  assign push      = job_valid_i && ready_q;
  assign head      = mem[rd_ptr];
  assign head_zero = (head.m == '0) || (head.k == '0) || (head.n == '0);

  // Occupancy bookkeeping for push/pop
  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + LvlW'(1);
      2'b01:   level_next = level - LvlW'(1);
      default: level_next = level;
    endcase
  end

  // Storage array; contents need no reset since level qualifies them
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{id: job_id_i, m: job_m_i, k: job_k_i, n: job_n_i};
  end

  // Pointers, occupancy and registered ready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      level   <= level_next;
      ready_q <= (level_next != LvlW'(QueueDepth));
    end
  end

  // ----------------------------------------------------------------- FSM
  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Next state, FIFO pop and control outputs
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    gemm_start_o = 1'b0;
    cpl_valid_o  = 1'b0;
    busy_o       = 1'b1;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (level != '0) begin
          pop        = 1'b1;
          // A zero-sized job is never sent to the accelerator
          state_next = head_zero ? CPL : START;
        end
      end
      START: begin
        gemm_start_o = 1'b1;
        state_next   = RUN;
      end
      RUN: begin
        if (gemm_done_i) state_next = CPL;
      end
      CPL: begin
        cpl_valid_o = 1'b1;
        if (cpl_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  // Saturating increment of the run counter
  assign run_inc = (&run_cnt) ? run_cnt : run_cnt + CycleWidth'(1);

  // Latch the job on pop, count run cycles, capture the count on done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gemm_m_size_o <= '0;
      gemm_k_size_o <= '0;
      gemm_n_size_o <= '0;
      tag_q         <= '0;
      err_q         <= 1'b0;
      cycles_q      <= '0;
      run_cnt       <= '0;
    end else begin
      if (pop) begin
        gemm_m_size_o <= head.m;
        gemm_k_size_o <= head.k;
        gemm_n_size_o <= head.n;
        tag_q         <= head.id;
        err_q         <= head_zero;
        cycles_q      <= '0;
      end
      if (state == START) run_cnt <= CycleWidth'(1);
      if (state == RUN) begin
        if (gemm_done_i) cycles_q <= run_inc;  // count includes the done cycle
        else             run_cnt  <= run_inc;
      end
    end
  end

  assign job_ready_o   = ready_q;
  assign cpl_id_o      = tag_q;
  assign cpl_cycles_o  = cycles_q;
  assign cpl_err_o     = err_q;
  assign queue_level_o = level;

endmodule
